conv_enc_k7: RTL and testbench

Rate-1/2, constraint-length-7 convolutional encoder with trellis termination. It is the transmit-side counterpart of the 64-state Viterbi decoder, and its output symbol pairs feed the decoder's branch-metric units directly. It accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code pair per input bit. After the last data bit it appends six zero tail bits, so the decoder always starts and ends in state 0.

---
 rtl/vit_pkg.sv | 19 +
 rtl/conv_enc_k7.sv | 97 +++++++++
 tb/tb_conv_enc_k7.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vit_pkg.sv
// rtl/vit_pkg.sv - shared constants, state type and parity helper for the K=7 encoder/decoder pair
package vit_pkg;

    localparam int K = 7;
    localparam logic [K-1:0] G0_DEF = 7'o171;
    localparam logic [K-1:0] G1_DEF = 7'o133;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // XOR of the tap vector bits selected by the generator polynomial
    function automatic logic parity7(input logic [K-1:0] vec, input logic [K-1:0] poly);
        return ^(vec & poly);
    endfunction

endpackage

// File: rtl/conv_enc_k7.sv
// rtl/conv_enc_k7.sv - rate-1/2 K=7 convolutional encoder with six-bit zero tail termination
module conv_enc_k7
    import vit_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    // Index of the sixth (final) tail pair.
    localparam logic [2:0] TAIL_LAST = 3'(K - 2);

    enc_state_t state;
    logic [5:0] sr;
    logic [2:0] tail_cnt;

    logic       slot_free;
    logic       accept_in;
    logic       tail_step;
    logic       tail_final;
    logic       load;
    logic       u;
    logic [6:0] tap_vec;
    logic [1:0] next_pair;

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state != TAIL) && slot_free;
    assign accept_in  = in_valid && in_ready;
    assign tail_step  = (state == TAIL) && slot_free;
    assign tail_final = tail_step && (tail_cnt == TAIL_LAST);
    assign load       = accept_in || tail_step;
    // In TAIL no input is accepted, so the injected bit is always zero.
    assign u          = accept_in ? in_bit : 1'b0;

    // Tap vector: current bit in the MSB, then history from newest to oldest.
    always_comb begin
        tap_vec   = {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
        next_pair = {parity7(tap_vec, G0), parity7(tap_vec, G1)};
    end

    // Frame control: shift register, tail counter and IDLE/DATA/TAIL sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            tail_cnt <= '0;
        end else if (accept_in) begin
            sr    <= {sr[4:0], in_bit};
            state <= in_last ? TAIL : DATA;
        end else if (tail_step) begin
            sr <= {sr[4:0], 1'b0};
            if (tail_final) begin
                tail_cnt <= '0;
                state    <= IDLE;
            end else begin
                tail_cnt <= tail_cnt + 3'd1;
            end
        end
    end

    // Single-entry output slot; reloads in the same cycle it is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pair  <= next_pair;
            out_last  <= tail_final;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Busy covers the whole frame, including a final tail pair still waiting downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= load || (state != IDLE) || (out_valid && !out_ready);
        end
    end

endmodule

// File: tb/tb_conv_enc_k7.sv
// tb/tb_conv_enc_k7.sv - self-checking bench for conv_enc_k7 against a convolution model
module tb_conv_enc_k7;

    typedef struct packed {
        logic [1:0] pair;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_pair;
    logic       out_last;
    logic       busy;

    int vectors = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t got_q[$];

    int or_mode = 0;
    int or_pct = 100;
    int or_phase = 0;

    logic [1:0] imp_ref [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

    conv_enc_k7 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected pairs of a terminated frame: direct convolution of bits+6 zeros with 171/133.
    task automatic model_frame(input logic bits[$], output exp_t q[$]);
        logic [6:0] g0;
        logic [6:0] g1;
        int n;
        logic b;
        logic p0;
        logic p1;
        exp_t e;
        g0 = 7'o171;
        g1 = 7'o133;
        n = bits.size();
        q = {};
        for (int j = 0; j < n + 6; j++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int d = 0; d < 7; d++) begin
                b = (j - d >= 0 && j - d < n) ? bits[j - d] : 1'b0;
                p0 = p0 ^ (b & g0[6 - d]);
                p1 = p1 ^ (b & g1[6 - d]);
            end
            e.pair = {p0, p1};
            e.last = (j == n + 5);
            q.push_back(e);
        end
    endtask

    // Downstream ready generator: 0 = always, 1 = random, 2 = pattern 1,0,0
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < or_pct);
                default: begin
                    out_ready = (or_phase % 3 == 0);
                    or_phase++;
                end
            endcase
        end
    end

    // Compare process: every accepted pair against the model, hold-stability while stalled,
    // and in_ready low during tail generation.
    initial begin
        logic       hold_pending;
        logic [1:0] held_pair;
        logic       held_last;
        logic       tail_phase;
        exp_t       e;
        exp_t       g;
        hold_pending = 1'b0;
        tail_phase = 1'b0;
        held_pair = 2'b00;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pending = 1'b0;
                tail_phase = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_pair", 32'(out_pair), 32'(held_pair));
                    check("hold_last", 32'(out_last), 32'(held_last));
                end
                if (tail_phase && !(out_valid && out_last))
                    check("tail_in_ready", 32'(in_ready), 32'd0);
                if (out_valid && out_last)
                    tail_phase = 1'b0;
                if (in_valid && in_ready && in_last)
                    tail_phase = 1'b1;
                if (out_valid && out_ready) begin
                    g.pair = out_pair;
                    g.last = out_last;
                    got_q.push_back(g);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_pair: got %b with nothing expected at %0t", out_pair, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pair", 32'(out_pair), 32'(e.pair));
                        check("last", 32'(out_last), 32'(e.last));
                    end
                    if (!out_last)
                        check("busy_in_frame", 32'(busy), 32'd1);
                end
                hold_pending = out_valid && !out_ready;
                held_pair = out_pair;
                held_last = out_last;
            end
        end
    end

    // Drive one frame; caller and task stay aligned 1 time unit after a rising edge.
    task automatic send_frame(input logic bits[$], input int gap_pct);
        exp_t q[$];
        int cnt;
        logic acc;
        model_frame(bits, q);
        foreach (q[i]) exp_q.push_back(q[i]);
        for (int i = 0; i < bits.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_bit = bits[i];
            in_last = (i == bits.size() - 1);
            cnt = 0;
            forever begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                cnt++;
                if (cnt > 2000) begin
                    vectors++;
                    errors++;
                    $display("FAIL in_ready_timeout: bit %0d never accepted", i);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_impulse(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            check({tag, "_pair"}, 32'(got_q[i].pair), 32'(imp_ref[i]));
            check({tag, "_last"}, 32'(got_q[i].last), 32'(i == 6));
        end
    endtask

    initial begin
        logic bits[$];
        exp_t q[$];
        int n;
        int cnt;

        // model pinned to the hand-derived impulse response
        bits = {1'b1};
        model_frame(bits, q);
        check("model_imp_count", 32'(q.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("model_imp_pair", 32'(q[i].pair), 32'(imp_ref[i]));
        bits = {1'b0, 1'b1};
        model_frame(bits, q);
        check("model_shift_pair0", 32'(q[0].pair), 32'd0);
        check("model_shift_pair7", 32'(q[7].pair), 32'b11);

        // reset state
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pair", 32'(out_pair), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // impulse, free-running output
        or_mode = 0;
        got_q = {};
        bits = {1'b1};
        send_frame(bits, 0);
        drain();
        check_impulse("impulse");

        // all-zero frame of 10 bits
        got_q = {};
        bits = {};
        for (int i = 0; i < 10; i++) bits.push_back(1'b0);
        send_frame(bits, 0);
        drain();
        check("zero_count", 32'(got_q.size()), 32'd16);
        foreach (got_q[i]) begin
            check("zero_pair", 32'(got_q[i].pair), 32'd0);
            check("zero_last", 32'(got_q[i].last), 32'(i == 15));
        end

        // impulse under 1,0,0 backpressure
        or_mode = 2;
        or_phase = 0;
        got_q = {};
        bits = {1'b1};
        send_frame(bits, 0);
        drain();
        check_impulse("bp_impulse");

        // back-to-back frames [1,0,1] then [1]
        or_mode = 0;
        got_q = {};
        bits = {1'b1, 1'b0, 1'b1};
        send_frame(bits, 0);
        bits = {1'b1};
        send_frame(bits, 0);
        drain();
        check("b2b_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() > 9) check("b2b_first_pair", 32'(got_q[9].pair), 32'b11);

        // asynchronous reset mid-tail, after the 3rd tail pair
        got_q = {};
        bits = {1'b1};
        send_frame(bits, 0);
        cnt = 0;
        while (got_q.size() < 4 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("mid_tail_reached", 32'(got_q.size()), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q = {};
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_last", 32'(out_last), 32'd0);
        check("async_rst_pair", 32'(out_pair), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        got_q = {};
        bits = {1'b1};
        send_frame(bits, 0);
        drain();
        check_impulse("post_rst_impulse");

        // random frames with random backpressure and input gaps
        or_mode = 1;
        for (int f = 0; f < 12; f++) begin
            or_pct = $urandom_range(30, 100);
            n = $urandom_range(1, 200);
            if (f == 0) n = 1;
            if (f == 1) n = 200;
            bits = {};
            for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
            got_q = {};
            send_frame(bits, 20);
            drain();
            check("rand_count", 32'(got_q.size()), 32'(n + 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
